// File: rtl/add_seq_pkg.sv
// Shared types and constants for the adder operand sequencer.
// State encoding matches the LED display: LOAD_A=0, LOAD_B=1, CALC=2, SHOW=3.
package add_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted 0->1 transition (release gives no pulse).
module btn_debounce #(
  parameter int DB_COUNT = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic press
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
    end
  end

  // The stable level only moves after the synced level has disagreed with it
  // for DB_COUNT consecutive cycles; any agreement restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/add_operand_seq.sv
// Operand sequencer and result capture for an external combinational adder.
// Define ACCUM_EN for running-total mode with a sticky overflow flag.
module add_operand_seq
  import add_seq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DB_COUNT = 500000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW,
  input  logic             BTN,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  input  logic [WIDTH-1:0] ADD_S,
  input  logic             ADD_CO,
  output logic [WIDTH:0]   RESULT,
  output logic             VALID,
  output logic             OVF,
  output logic [1:0]       STATE
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_result;
  logic             r_valid;
  logic             w_press;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_capture;
  logic             w_clear_valid;
  logic             w_a_from_result;

  btn_debounce #(
    .DB_COUNT(DB_COUNT)
  ) u_btn_debounce (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BTN  (BTN),
    .press(w_press)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // CALC always lasts one cycle, so a press landing there is simply ignored.
  always_comb begin
    w_next_state    = r_state;
    w_load_a        = 1'b0;
    w_load_b        = 1'b0;
    w_capture       = 1'b0;
    w_clear_valid   = 1'b0;
    w_a_from_result = 1'b0;
    case (r_state)
      LOAD_A: begin
        if (w_press) begin
          w_load_a     = 1'b1;
          w_next_state = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_press) begin
          w_load_b     = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        w_capture    = 1'b1;
        w_next_state = SHOW;
      end
      SHOW: begin
        if (w_press) begin
          w_clear_valid = 1'b1;
`ifdef ACCUM_EN
          w_a_from_result = 1'b1;
          w_next_state    = LOAD_B;
`else
          w_next_state    = LOAD_A;
`endif
        end
      end
      default: w_next_state = LOAD_A;
    endcase
  end

  // RESULT survives a return to LOAD_A and only changes at the next CALC.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_load_a) begin
        r_a <= SW;
      end else if (w_a_from_result) begin
        r_a <= r_result[WIDTH-1:0];
      end
      if (w_load_b) begin
        r_b <= SW;
      end
      if (w_capture) begin
        r_result <= {ADD_CO, ADD_S};
        r_valid  <= 1'b1;
      end else if (w_clear_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef ACCUM_EN
  logic r_ovf;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_capture) begin
      r_ovf <= r_ovf | ADD_CO;
    end
  end

  assign OVF = r_ovf;
`else
  assign OVF = r_result[WIDTH];
`endif

  assign ADD_A  = r_a;
  assign ADD_B  = r_b;
  assign RESULT = r_result;
  assign VALID  = r_valid;
  assign STATE  = r_state;

endmodule

// File: tb/tb_add_operand_seq.sv
// Bench for add_operand_seq paired with a behavioural 4-bit adder; results
// are predicted into a scoreboard queue and checked when VALID appears.
module tb_add_operand_seq;

  localparam int W  = 4;
  localparam int DB = 4;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [W-1:0] SW = '0;
  logic         BTN = 1'b0;
  logic [W-1:0] ADD_A;
  logic [W-1:0] ADD_B;
  logic [W-1:0] ADD_S;
  logic         ADD_CO;
  logic [W:0]   RESULT;
  logic         VALID;
  logic         OVF;
  logic [1:0]   STATE;

  int errors = 0;
  int checks = 0;
  logic [W:0] expQ[$];

  add_operand_seq #(.WIDTH(W), .DB_COUNT(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .BTN(BTN),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_S(ADD_S), .ADD_CO(ADD_CO),
    .RESULT(RESULT), .VALID(VALID), .OVF(OVF), .STATE(STATE)
  );

  assign {ADD_CO, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B};

  always #5 CLK = ~CLK;

  // Clean press: hold SW, raise BTN 10 cycles, release 10 cycles.
  task automatic applyStimulus(input logic [W-1:0] val);
    @(negedge CLK);
    SW  = val;
    BTN = 1'b1;
    repeat (10) @(negedge CLK);
    BTN = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (VALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST_N = 1'b0;
    BTN   = 1'b0;
    SW    = '0;
    expQ.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (STATE !== 2'd0 || RESULT !== 5'h00 || VALID !== 1'b0 || OVF !== 1'b0 ||
        ADD_A !== 4'h0 || ADD_B !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset: state=%0d result=%h valid=%b ovf=%b a=%h b=%h, need all zero",
               STATE, RESULT, VALID, OVF, ADD_A, ADD_B);
    end
  endtask

  task automatic test_basic_add();
    bit ok;
    bit seen;
    doReset();
    applyStimulus(4'h3);
    checks++;
    if (STATE !== 2'd1 || ADD_A !== 4'h3) begin
      errors++;
      $display("[TB] FAIL load_a: state=%0d a=%h, need 1/3", STATE, ADD_A);
    end
    @(negedge CLK);
    SW  = 4'h4;
    BTN = 1'b1;
    expQ.push_back(5'h07);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (STATE === 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || VALID !== 1'b0 || ADD_B !== 4'h4) begin
      errors++;
      $display("[TB] FAIL calc_entry: seen=%b valid=%b b=%h, need 1/0/4", seen, VALID, ADD_B);
    end
    @(negedge CLK);
    checks++;
    if (STATE !== 2'd3 || VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL valid_after_calc: state=%0d valid=%b, need 3/1", STATE, VALID);
    end
    repeat (9) @(negedge CLK);
    BTN = 1'b0;
    repeat (10) @(negedge CLK);
    waitValid(ok);
    checks++;
    if (!ok || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL sum_3_4: timeout waiting for VALID");
    end else begin
      logic [W:0] e;
      e = expQ.pop_front();
      if (RESULT !== e) begin
        errors++;
        $display("[TB] FAIL sum_3_4: result=%h need %h", RESULT, e);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    doReset();
    applyStimulus(4'hF);
    expQ.push_back(5'h1E);
    applyStimulus(4'hF);
    waitValid(ok);
    checks++;
    if (!ok || expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL sum_f_f: timeout waiting for VALID");
    end else begin
      logic [W:0] e;
      e = expQ.pop_front();
      if (RESULT !== e) begin
        errors++;
        $display("[TB] FAIL sum_f_f: result=%h need %h", RESULT, e);
      end
    end
    checks++;
    if (OVF !== 1'b1 || STATE !== 2'd3) begin
      errors++;
      $display("[TB] FAIL ovf_f_f: ovf=%b state=%0d, need 1/3", OVF, STATE);
    end
`ifndef ACCUM_EN
    applyStimulus(4'h5);
    checks++;
    if (STATE !== 2'd0 || VALID !== 1'b0 || RESULT !== 5'h1E || OVF !== 1'b1 || ADD_A !== 4'hF) begin
      errors++;
      $display("[TB] FAIL show_exit: state=%0d valid=%b result=%h ovf=%b a=%h, need 0/0/1e/1/f",
               STATE, VALID, RESULT, OVF, ADD_A);
    end
`endif
  endtask

  task automatic test_bounce();
    bit stayed;
    doReset();
    stayed = 1'b1;
    for (int len = 1; len <= 3; len++) begin
      @(negedge CLK);
      BTN = 1'b1;
      repeat (len) @(negedge CLK);
      BTN = 1'b0;
      for (int g = 0; g < 8; g++) begin
        @(negedge CLK);
        if (STATE !== 2'd0) stayed = 1'b0;
      end
    end
    checks++;
    if (!stayed || STATE !== 2'd0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: stayed=%b state=%0d, need 1/0", stayed, STATE);
    end
    applyStimulus(4'h6);
    repeat (10) @(negedge CLK);
    checks++;
    if (STATE !== 2'd1 || ADD_A !== 4'h6) begin
      errors++;
      $display("[TB] FAIL single_press: state=%0d a=%h, need 1/6", STATE, ADD_A);
    end
  endtask

  task automatic test_reset_midway();
    doReset();
    applyStimulus(4'h9);
    checks++;
    if (STATE !== 2'd1 || ADD_A !== 4'h9) begin
      errors++;
      $display("[TB] FAIL pre_reset_load: state=%0d a=%h, need 1/9", STATE, ADD_A);
    end
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (STATE !== 2'd0 || ADD_A !== 4'h0 || ADD_B !== 4'h0 || RESULT !== 5'h00 ||
        VALID !== 1'b0 || OVF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: state=%0d a=%h b=%h result=%h valid=%b ovf=%b, need zeros",
               STATE, ADD_A, ADD_B, RESULT, VALID, OVF);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

`ifdef ACCUM_EN
  task automatic test_accum();
    bit ok;
    logic [W:0] e;
    doReset();
    applyStimulus(4'h8);
    expQ.push_back(5'h0F);
    applyStimulus(4'h7);
    waitValid(ok);
    e = (expQ.size() != 0) ? expQ.pop_front() : 5'h00;
    checks++;
    if (!ok || RESULT !== e || OVF !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accum_8_7: ok=%b result=%h ovf=%b, need 1/%h/0", ok, RESULT, OVF, e);
    end
    applyStimulus(4'h0);
    checks++;
    if (STATE !== 2'd1 || ADD_A !== 4'hF || VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accum_reload: state=%0d a=%h valid=%b, need 1/f/0", STATE, ADD_A, VALID);
    end
    expQ.push_back(5'h11);
    applyStimulus(4'h2);
    waitValid(ok);
    e = (expQ.size() != 0) ? expQ.pop_front() : 5'h00;
    checks++;
    if (!ok || RESULT !== e || OVF !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accum_f_2: ok=%b result=%h ovf=%b, need 1/%h/1", ok, RESULT, OVF, e);
    end
    applyStimulus(4'h0);
    expQ.push_back(5'h04);
    applyStimulus(4'h3);
    waitValid(ok);
    e = (expQ.size() != 0) ? expQ.pop_front() : 5'h00;
    checks++;
    if (!ok || RESULT !== e || OVF !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accum_sticky: ok=%b result=%h ovf=%b, need 1/%h/1", ok, RESULT, OVF, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_overflow();
    test_bounce();
    test_reset_midway();
`ifdef ACCUM_EN
    test_accum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_operand_seq.md
Name: add_operand_seq

Overview:
- Upstream operand sequencer and result capture for the 4-bit ripple-carry adder.
- Takes operands from the board switches using a single push button, one press per operand.
- Drives the adder's A/B inputs from registers, then captures the adder's {Co,S} into a registered RESULT with a VALID flag for the LED/display stage.
- The adder itself stays outside this block and is combinational; this block only feeds it and samples it.

Parameters:
- WIDTH, 4, operand width; must match the adder width.
- DB_COUNT, 500000, number of stable cycles before a button change is accepted (5 ms at 100 MHz). Benches use 4.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- SW  input  WIDTH  operand switches; asynchronous to CLK and sampled only on an accepted press.
- BTN  input  1  raw, bouncing, asynchronous push button.
- ADD_A  output  WIDTH  operand A to the adder; equals reg_a.
- ADD_B  output  WIDTH  operand B to the adder; equals reg_b.
- ADD_S  input  WIDTH  sum from the adder.
- ADD_CO  input  1  carry-out from the adder.
- RESULT  output  WIDTH+1  captured {ADD_CO, ADD_S}.
- VALID  output  1  high while RESULT holds a completed sum.
- OVF  output  1  overflow indicator (see Optional Feature).
- STATE  output  2  current FSM state, for the LEDs.

Behaviour:
- Reset (async, RST_N=0):
  - reg_a, reg_b, RESULT = 0; VALID = 0; OVF = 0.
  - Synchronizer and debounce state = 0; FSM = LOAD_A.
  - Reset mid-operation abandons any partial entry.
- Button path:
  - 2-flop synchronizer on BTN.
  - Debounce counter counts while the synced value differs from the stable value and clears when they are equal.
  - When the counter reaches DB_COUNT-1, the stable value takes the synced value and the counter clears.
  - press = one-cycle pulse on a 0->1 edge of the stable value.
  - Release produces no pulse.
  - Latency from a clean BTN edge to press is 2 + DB_COUNT cycles.
- FSM encoding: LOAD_A=0, LOAD_B=1, CALC=2, SHOW=3.
  - LOAD_A, on press: reg_a <= SW; go to LOAD_B.
  - LOAD_B, on press: reg_b <= SW; go to CALC.
  - CALC: unconditional single cycle. RESULT <= {ADD_CO, ADD_S}; VALID <= 1 on the next edge; go to SHOW. A press arriving in CALC is dropped.
  - SHOW: VALID held at 1 and RESULT held. On press: VALID <= 0 and the default path goes to LOAD_A. RESULT is not cleared; it keeps the old value until the next CALC.
- Adder timing: the adder sees the new reg_b one full cycle before CALC samples it, so no combinational path from ADD_S to RESULT is needed within the same cycle.
- Arithmetic: unsigned. RESULT[WIDTH] is the carry. 4'hF + 4'hF = 5'h1E.
- Presses are spaced at least DB_COUNT cycles apart, so at most one state advance happens per press.

Optional Feature:
- Macro: ACCUM_EN.
- Defined (running-total mode):
  - A press in SHOW loads reg_a <= RESULT[WIDTH-1:0], clears VALID, and goes to LOAD_B instead of LOAD_A.
  - OVF is sticky: it ORs in ADD_CO at every CALC.
  - OVF is cleared on reset only.
- Not defined:
  - A press in SHOW goes to LOAD_A as described above.
  - OVF = RESULT[WIDTH], combinational from the RESULT register.
- The port list is identical in both builds.

Decomposition:
- Package add_seq_pkg:
  - state_t enum (LOAD_A, LOAD_B, CALC, SHOW, 2-bit).
  - Default operand width constant.
- Sub-module btn_debounce:
  - Synchronizer, debounce counter of width $clog2(DB_COUNT), and rising-edge pulse.
  - Ports: CLK, RST_N, BTN, press.
- The FSM and registers stay in add_operand_seq.
- Benches pair add_operand_seq with the existing adder: ADD_A/ADD_B to A/B, S/Co to ADD_S/ADD_CO.

Test Plan (DB_COUNT=4, adder connected):
- Reset -> STATE=0, RESULT=0, VALID=0, OVF=0, ADD_A=ADD_B=0.
- Enter SW=3 and press, then SW=4 and press -> STATE steps 0->1->2->3; RESULT=5'h07; VALID rises exactly one cycle after CALC.
- Enter SW=F then SW=F -> RESULT=5'h1E; OVF=1 in the non-ACCUM build.
- Bouncing BTN with glitches shorter than 4 cycles -> no press and STATE unchanged. A 10-cycle clean pulse -> exactly one press.
- Drop RST_N during LOAD_B after loading A=9 -> all outputs return to reset values and STATE=0 immediately, without waiting for a clock edge.
- ACCUM_EN build, sequence 8+7 then press, enter 2 -> reg_a=F, RESULT=5'h11, OVF=1, and OVF stays 1 through subsequent no-carry sums.
